// File: rtl/bicubic_phase_gen_pkg.sv
// Shared widths, state encoding and constants for the bicubic phase generator
// and the weight units it feeds.
package bicubic_phase_gen_pkg;

  localparam int IDX_W   = 12;
  localparam int FRAC_W  = 8;
  localparam int STEP_W  = IDX_W + FRAC_W;
  localparam int ACC_W   = IDX_W + FRAC_W + 2;
  localparam int BLEND_W = FRAC_W + 1;

  localparam int COEFF_ONE = 1 << FRAC_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/bicubic_phase_gen_if.sv
// Position stream from the phase generator to the line-buffer reader and
// weight units.
interface bicubic_phase_gen_if;
  import bicubic_phase_gen_pkg::*;

  // A position transfers on every clock edge where out_valid and out_ready are
  // both high; while out_valid is high and out_ready low the producer holds all
  // payload fields stable, and out_valid never drops without a transfer.
  logic               out_valid;
  logic               out_ready;
  logic [BLEND_W-1:0] out_blend;
  logic [IDX_W-1:0]   out_tap0;
  logic [IDX_W-1:0]   out_tap1;
  logic [IDX_W-1:0]   out_tap2;
  logic [IDX_W-1:0]   out_tap3;
  logic               out_first;
  logic               out_last;

  modport master (
    output out_valid, out_blend, out_tap0, out_tap1, out_tap2, out_tap3,
           out_first, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_blend, out_tap0, out_tap1, out_tap2, out_tap3,
           out_first, out_last,
    output out_ready
  );

endinterface

// File: rtl/bicubic_phase_gen_tap_clamp.sv
// Converts a signed fixed-point source position into the blend fraction and
// four edge-clamped source taps.
module bicubic_tap_clamp
  import bicubic_phase_gen_pkg::*;
(
  input  logic signed [ACC_W-1:0] pos,
  input  logic [IDX_W-1:0]        src_size,
  output logic [BLEND_W-1:0]      blend,
  output logic [IDX_W-1:0]        tap0,
  output logic [IDX_W-1:0]        tap1,
  output logic [IDX_W-1:0]        tap2,
  output logic [IDX_W-1:0]        tap3
);

  localparam int IPAD = ACC_W - FRAC_W - IDX_W;
  localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);
  localparam logic [IDX_W:0]   ONE_X   = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   TWO_X   = (IDX_W + 1)'(2);

  logic [ACC_W-1:0]        pos_c;
  logic [ACC_W-FRAC_W-1:0] idx_raw;
  logic [IDX_W-1:0]        idx_max;
  logic [IDX_W-1:0]        idx;
  logic [FRAC_W-1:0]       frac;
  logic [IDX_W:0]          up1;
  logic [IDX_W:0]          up2;

  always_comb begin
    pos_c   = pos[ACC_W-1] ? '0 : pos;
    idx_raw = pos_c[ACC_W-1:FRAC_W];
    idx_max = src_size - ONE_IDX;
    // Past the bottom edge the position pins to the last row with no blend.
    if (idx_raw > {{IPAD{1'b0}}, idx_max}) begin
      idx  = idx_max;
      frac = '0;
    end else begin
      idx  = idx_raw[IDX_W-1:0];
      frac = pos_c[FRAC_W-1:0];
    end
    up1   = {1'b0, idx} + ONE_X;
    up2   = {1'b0, idx} + TWO_X;
    tap0  = (idx == '0) ? '0 : idx - ONE_IDX;
    tap1  = idx;
    tap2  = (up1 > {1'b0, idx_max}) ? idx_max : up1[IDX_W-1:0];
    tap3  = (up2 > {1'b0, idx_max}) ? idx_max : up2[IDX_W-1:0];
    blend = {1'b0, frac};
  end

endmodule

// File: rtl/bicubic_phase_gen.sv
// Per-frame generator of center-aligned bicubic sample positions, one per
// destination row (or column), streamed over a valid/ready interface.
module bicubic_phase_gen
  import bicubic_phase_gen_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W-1:0]     src_size,
  input  logic [IDX_W-1:0]     dst_size,
  input  logic [STEP_W-1:0]    scale_step,
  bicubic_phase_gen_if.master  out_if,
  output logic                 busy,
  output logic                 done,
  output state_t               state_dbg
);

  localparam logic [IDX_W-1:0]        ONE_IDX  = IDX_W'(1);
  localparam logic signed [ACC_W-1:0] HALF_ACC = ACC_W'(COEFF_ONE / 2);

  state_t state;
  state_t state_next;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_init;
  logic signed [ACC_W-1:0] acc_step;
  logic signed [ACC_W-1:0] load_val;
  logic [IDX_W-1:0]        count;
  logic [IDX_W-1:0]        count_next;
  logic [IDX_W-1:0]        cfg_src;
  logic [IDX_W-1:0]        cfg_dst;
  logic [STEP_W-1:0]       cfg_step;
  logic                    hs;
  logic                    final_hs;
  logic                    last_next;

  logic [BLEND_W-1:0] c_blend;
  logic [IDX_W-1:0]   c_tap0, c_tap1, c_tap2, c_tap3;

  logic               r_valid, r_first, r_last;
  logic [BLEND_W-1:0] r_blend;
  logic [IDX_W-1:0]   r_tap0, r_tap1, r_tap2, r_tap3;

  // Center alignment: the first position is half a step minus half a pixel.
  assign acc_init   = $signed({2'b00, 1'b0, cfg_step[STEP_W-1:1]}) - HALF_ACC;
  assign acc_step   = acc + $signed({2'b00, cfg_step});
  assign load_val   = (state == LOAD) ? acc_init : acc_step;
  assign count_next = (state == LOAD) ? '0 : count + ONE_IDX;
  assign last_next  = (count_next == cfg_dst - ONE_IDX);
  assign hs         = r_valid & out_if.out_ready;
  assign final_hs   = hs & (count == cfg_dst - ONE_IDX);

  bicubic_tap_clamp u_clamp (
    .pos      (load_val),
    .src_size (cfg_src),
    .blend    (c_blend),
    .tap0     (c_tap0),
    .tap1     (c_tap1),
    .tap2     (c_tap2),
    .tap3     (c_tap3)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (cfg_dst == '0) ? DONE : RUN;
      RUN:     if (final_hs) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      cfg_src  <= '0;
      cfg_dst  <= '0;
      cfg_step <= '0;
      r_valid  <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_blend  <= '0;
      r_tap0   <= '0;
      r_tap1   <= '0;
      r_tap2   <= '0;
      r_tap3   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_src  <= src_size;
            cfg_dst  <= dst_size;
            cfg_step <= scale_step;
          end
        end
        LOAD: begin
          if (cfg_dst != '0) begin
            acc     <= acc_init;
            count   <= '0;
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= last_next;
            r_blend <= c_blend;
            r_tap0  <= c_tap0;
            r_tap1  <= c_tap1;
            r_tap2  <= c_tap2;
            r_tap3  <= c_tap3;
          end
        end
        RUN: begin
          if (final_hs) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
          end else if (hs) begin
            acc     <= acc_step;
            count   <= count_next;
            r_first <= 1'b0;
            r_last  <= last_next;
            r_blend <= c_blend;
            r_tap0  <= c_tap0;
            r_tap1  <= c_tap1;
            r_tap2  <= c_tap2;
            r_tap3  <= c_tap3;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_first = r_first;
  assign out_if.out_last  = r_last;
  assign out_if.out_blend = r_blend;
  assign out_if.out_tap0  = r_tap0;
  assign out_if.out_tap1  = r_tap1;
  assign out_if.out_tap2  = r_tap2;
  assign out_if.out_tap3  = r_tap3;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Directed bench for bicubic_phase_gen: hand-computed positions go into an
// expected queue and a negedge monitor checks every handshake against it.
module tb_bicubic_phase_gen;
  import bicubic_phase_gen_pkg::*;

  localparam int EW = 2 + BLEND_W + 4 * IDX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IDX_W-1:0]  src_size;
  logic [IDX_W-1:0]  dst_size;
  logic [STEP_W-1:0] scale_step;
  logic              busy;
  logic              done;
  state_t            state_dbg;

  bicubic_phase_gen_if bus ();

  bicubic_phase_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_size   (src_size),
    .dst_size   (dst_size),
    .scale_step (scale_step),
    .out_if     (bus),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int last_hs_cyc = 0;
  bit hs_pending = 0;
  bit prev_stall = 0;
  bit prev_done = 0;
  logic [EW-1:0] prev_word;
  logic [EW-1:0] cur_word;

  assign cur_word = {bus.out_first, bus.out_last, bus.out_blend,
                     bus.out_tap0, bus.out_tap1, bus.out_tap2, bus.out_tap3};

  function automatic logic [EW-1:0] mk(input bit f, input bit l, input int b,
                                       input int t0, input int t1,
                                       input int t2, input int t3);
    return {f, l, BLEND_W'(b), IDX_W'(t0), IDX_W'(t1), IDX_W'(t2), IDX_W'(t3)};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_done  = 0;
      hs_pending = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_word", 64'(cur_word), 64'(prev_word));
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_position: got %0h expected none", cur_word);
        end else begin
          check("position", 64'(cur_word), 64'(exp_q.pop_front()));
        end
        if (bus.out_last) begin
          hs_pending  = 1;
          last_hs_cyc = cyc;
        end
      end
      if (done) begin
        check("done_width", 64'(prev_done), 64'd0);
        if (hs_pending) check("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
        hs_pending = 0;
      end
      prev_done  = done;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = cur_word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int s, input int d, input int st);
    src_size   = IDX_W'(s);
    dst_size   = IDX_W'(d);
    scale_step = STEP_W'(st);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    tick();
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1;
        break;
      end
    end
    check({name, "_valid_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic push_1to1();
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 2));
    exp_q.push_back(mk(0, 0, 0, 0, 1, 2, 3));
    exp_q.push_back(mk(0, 0, 0, 1, 2, 3, 3));
    exp_q.push_back(mk(0, 1, 0, 2, 3, 3, 3));
  endtask

  task automatic push_up2();
    exp_q.push_back(mk(1, 0, 0,   0, 0, 1, 1));
    exp_q.push_back(mk(0, 0, 64,  0, 0, 1, 1));
    exp_q.push_back(mk(0, 0, 192, 0, 0, 1, 1));
    exp_q.push_back(mk(0, 1, 64,  0, 1, 1, 1));
  endtask

  task automatic push_down2();
    exp_q.push_back(mk(1, 0, 128, 0, 0, 1, 2));
    exp_q.push_back(mk(0, 0, 128, 1, 2, 3, 4));
    exp_q.push_back(mk(0, 0, 128, 3, 4, 5, 6));
    exp_q.push_back(mk(0, 1, 128, 5, 6, 7, 7));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    src_size      = '0;
    dst_size      = '0;
    scale_step    = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_word", 64'(cur_word), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    tick();
    rst = 1'b0;
    tick();

    // 1:1 scaling
    bus.out_ready = 1'b1;
    push_1to1();
    hs_cnt = 0;
    start_frame(4, 4, 256);
    wait_done("one_to_one");
    check("one_to_one_hs", 64'(hs_cnt), 64'd4);

    // 2x upscale
    push_up2();
    hs_cnt = 0;
    start_frame(2, 4, 128);
    wait_done("upscale");
    check("upscale_hs", 64'(hs_cnt), 64'd4);

    // 2x downscale
    push_down2();
    hs_cnt = 0;
    start_frame(8, 4, 512);
    wait_done("downscale");
    check("downscale_hs", 64'(hs_cnt), 64'd4);

    // back-pressure: stall position 1 once, position 2 for three cycles
    bus.out_ready = 1'b0;
    push_1to1();
    hs_cnt = 0;
    start_frame(4, 4, 256);
    wait_valid("bp");
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    bus.out_ready = 1'b1;
    wait_done("bp");
    check("bp_hs", 64'(hs_cnt), 64'd4);

    // empty frame
    start_frame(4, 0, 256);
    @(negedge clk);
    check("empty_busy_c1", 64'(busy), 64'd1);
    check("empty_done_c1", 64'(done), 64'd0);
    check("empty_valid_c1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("empty_busy_c2", 64'(busy), 64'd1);
    check("empty_done_c2", 64'(done), 64'd1);
    check("empty_valid_c2", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("empty_busy_c3", 64'(busy), 64'd0);
    check("empty_done_c3", 64'(done), 64'd0);
    tick();

    // start during RUN and DONE, src_size changed mid-frame
    push_down2();
    hs_cnt = 0;
    start_frame(8, 4, 512);
    src_size = IDX_W'(2);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      bit seen = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (done) begin
          seen  = 1;
          start = 1'b1;
          break;
        end
      end
      check("robust_done_seen", 64'(seen), 64'd1);
    end
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("start_in_done_ignored", 64'(busy), 64'd0);
    end
    check("robust_hs", 64'(hs_cnt), 64'd4);
    check("robust_queue_drained", 64'(exp_q.size()), 64'd0);
    tick();

    // reset mid-RUN abandons the frame
    bus.out_ready = 1'b0;
    start_frame(4, 4, 256);
    tick();
    @(negedge clk);
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_word", 64'(cur_word), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);
    tick();

    // clean frame after reset
    bus.out_ready = 1'b1;
    push_up2();
    hs_cnt = 0;
    start_frame(2, 4, 128);
    wait_done("after_reset");
    check("after_reset_hs", 64'(hs_cnt), 64'd4);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
